axi_rd_arbiter: RTL and testbench

AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

---
 rtl/axi_rd_arbiter.sv | 140 ++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter.sv
// Two-requester AXI read arbiter, round-robin, one read outstanding; grant -> arvalid next cycle, new grant the cycle after rlast.
// Backpressure: AR payload held until arready; R beats stall via the grantee's rready, which is passed straight through.
module axi_rd_arbiter #(
  parameter logic [3:0] ID0 = 4'd0,
  parameter logic [3:0] ID1 = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_arvalid,
  input  logic [31:0] m0_araddr,
  input  logic [7:0]  m0_arlen,
  input  logic [2:0]  m0_arsize,
  output logic        m0_arready,
  output logic [31:0] m0_rdata,
  output logic        m0_rvalid,
  output logic        m0_rlast,
  input  logic        m0_rready,
  input  logic        m1_arvalid,
  input  logic [31:0] m1_araddr,
  input  logic [7:0]  m1_arlen,
  input  logic [2:0]  m1_arsize,
  output logic        m1_arready,
  output logic [31:0] m1_rdata,
  output logic        m1_rvalid,
  output logic        m1_rlast,
  input  logic        m1_rready,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t      state, state_nxt;
  logic        last_grant;
  logic        gnt;
  logic [31:0] lat_addr;
  logic [7:0]  lat_len;
  logic [2:0]  lat_size;
  logic [7:0]  beat_cnt;
  logic        any_req;
  logic        pick;
  logic        in_data;
  logic        beat;
  logic        beat_err;

  // pick = 1 selects m1; on contention the side not served last wins
  assign any_req = m0_arvalid | m1_arvalid;
  assign pick    = (m0_arvalid & m1_arvalid) ? ~last_grant : m1_arvalid;

  always_comb begin
    state_nxt  = state;
    m0_arready = 1'b0;
    m1_arready = 1'b0;
    arvalid    = 1'b0;
    rready     = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          m0_arready = ~pick;
          m1_arready = pick;
          state_nxt  = ADDR;
        end
      end
      ADDR: begin
        arvalid = 1'b1;
        if (arready) state_nxt = DATA;
      end
      DATA: begin
        rready = gnt ? m1_rready : m0_rready;
        if (rvalid && rready && rlast) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign in_data = (state == DATA);
  assign beat    = in_data & rvalid & rready;

  assign m0_rvalid = in_data & ~gnt & rvalid;
  assign m0_rlast  = in_data & ~gnt & rlast;
  assign m1_rvalid = in_data & gnt & rvalid;
  assign m1_rlast  = in_data & gnt & rlast;
  assign m0_rdata  = rdata;
  assign m1_rdata  = rdata;

  assign arid    = gnt ? ID1 : ID0;
  assign araddr  = lat_addr;
  assign arlen   = lat_len;
  assign arsize  = lat_size;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;

  // Length checks compare the pre-increment count, i.e. the index of this beat
  assign beat_err = (rresp != 2'b00) || (rid != arid) ||
                    (rlast && (beat_cnt != lat_len)) ||
                    (!rlast && (beat_cnt == lat_len));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      gnt        <= 1'b0;
      lat_addr   <= '0;
      lat_len    <= '0;
      lat_size   <= '0;
      beat_cnt   <= '0;
      err        <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && any_req) begin
        gnt      <= pick;
        lat_addr <= pick ? m1_araddr : m0_araddr;
        lat_len  <= pick ? m1_arlen  : m0_arlen;
        lat_size <= pick ? m1_arsize : m0_arsize;
      end
      if (state == ADDR && arready) beat_cnt <= '0;
      else if (beat)                beat_cnt <= beat_cnt + 8'd1;
      if (beat && rlast) last_grant <= gnt;
      if (beat && beat_err) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Scoreboard bench for axi_rd_arbiter: bench acts as both requesters and the AXI slave.
module tb_axi_rd_arbiter;
  localparam logic [3:0] ID0 = 4'd0;
  localparam logic [3:0] ID1 = 4'd1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        m0_arvalid, m1_arvalid, m0_arready, m1_arready;
  logic [31:0] m0_araddr, m1_araddr, m0_rdata, m1_rdata;
  logic [7:0]  m0_arlen, m1_arlen;
  logic [2:0]  m0_arsize, m1_arsize;
  logic        m0_rvalid, m1_rvalid, m0_rlast, m1_rlast, m0_rready, m1_rready;
  logic [3:0]  arid, arcache, rid;
  logic [31:0] araddr, rdata;
  logic [7:0]  arlen;
  logic [2:0]  arsize, arprot;
  logic [1:0]  arburst, arlock, rresp;
  logic        arvalid, arready, rlast, rvalid, rready, err;

  axi_rd_arbiter #(.ID0(ID0), .ID1(ID1)) dut (
    .clk(clk), .rst(rst),
    .m0_arvalid(m0_arvalid), .m0_araddr(m0_araddr), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize),
    .m0_arready(m0_arready), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid), .m0_rlast(m0_rlast),
    .m0_rready(m0_rready),
    .m1_arvalid(m1_arvalid), .m1_araddr(m1_araddr), .m1_arlen(m1_arlen), .m1_arsize(m1_arsize),
    .m1_arready(m1_arready), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid), .m1_rlast(m1_rlast),
    .m1_rready(m1_rready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .err(err)
  );

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
  } ar_t;

  typedef struct packed {
    logic        who;
    logic [31:0] dat;
    logic        last;
  } r_t;

  ar_t  exp_ar[$];
  r_t   exp_r[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  logic exp_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic post();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input bit n, input logic [31:0] a, input logic [7:0] l);
    if (n) begin
      m1_arvalid = 1'b1; m1_araddr = a; m1_arlen = l; m1_arsize = 3'd2;
    end else begin
      m0_arvalid = 1'b1; m0_araddr = a; m0_arlen = l; m0_arsize = 3'd2;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; rvalid = 1'b0; rlast = 1'b0; arready = 1'b0;
    post();
    rst = 1'b0;
    exp_r.delete();
    exp_ar.delete();
    exp_err = 1'b0;
    chk("reset_err", err, 1'b0);
  endtask

  task automatic idle_check();
    @(negedge clk);
    chk("idle_arvalid", arvalid, 1'b0);
    chk("idle_rready", rready, 1'b0);
    chk("idle_arready", {m1_arready, m0_arready}, 2'b00);
    post();
  endtask

  // One full transaction for requester n, whose arvalid the caller has already raised.
  // last_at >= 0 ends the burst early; abort_at >= 0 resets the DUT before that beat.
  task automatic do_burst(input bit n, input int ar_dly, input logic [1:0] resp, input bit bad_rid,
                          input int last_at, input int stall_at, input int stall_len, input int abort_at);
    logic [31:0] a;
    logic [7:0]  l;
    int          nb;
    ar_t         ea;
    r_t          er;
    a  = n ? m1_araddr : m0_araddr;
    l  = n ? m1_arlen  : m0_arlen;
    nb = (last_at >= 0) ? last_at + 1 : int'(l) + 1;
    @(negedge clk);
    chk("grant", {m1_arready, m0_arready}, n ? 2'b10 : 2'b01);
    chk("idle_arvalid", arvalid, 1'b0);
    chk("idle_rready", rready, 1'b0);
    exp_ar.push_back('{n ? ID1 : ID0, a, l, 3'd2});
    for (int i = 0; i < nb; i++) exp_r.push_back('{n, a + 32'(i) * 4, i == nb - 1});
    if (resp != 2'b00 || bad_rid || last_at >= 0) exp_err = 1'b1;
    post();
    if (n) m1_arvalid = 1'b0; else m0_arvalid = 1'b0;

    for (int d = 0; d <= ar_dly; d++) begin
      arready = (d == ar_dly);
      @(negedge clk);
      chk("arvalid", arvalid, 1'b1);
      if (d == 0) chk("addr_rready", rready, 1'b0);
      if (d < ar_dly) chk("araddr_hold", araddr, a);
      else if (exp_ar.size() == 0) chk("ar_queue_empty", 32'd0, 32'd1);
      else begin
        ea = exp_ar.pop_front();
        chk("arid", arid, ea.id);
        chk("araddr", araddr, ea.addr);
        chk("arlen", arlen, ea.len);
        chk("arsize", arsize, ea.size);
        chk("arburst", arburst, 2'b01);
      end
      post();
    end
    arready = 1'b0;

    for (int i = 0; i < nb; i++) begin
      if (i == abort_at) begin
        rvalid = 1'b0; rst = 1'b1;
        post();
        rst = 1'b0; rvalid = 1'b1; rlast = 1'b0; rdata = a + 32'(i) * 4;
        @(negedge clk);
        chk("abort_arvalid", arvalid, 1'b0);
        chk("abort_rready", rready, 1'b0);
        chk("abort_err", err, 1'b0);
        chk("abort_rvalid", {m1_rvalid, m0_rvalid}, 2'b00);
        exp_r.delete();
        exp_err = 1'b0;
        post();
        rvalid = 1'b0;
        return;
      end
      rvalid = 1'b1;
      rdata  = a + 32'(i) * 4;
      rid    = (n ^ bad_rid) ? ID1 : ID0;
      rresp  = (i == 0) ? resp : 2'b00;
      rlast  = (i == nb - 1);
      if (i == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          if (n) m1_rready = 1'b0; else m0_rready = 1'b0;
          @(negedge clk);
          chk("stall_rready", rready, 1'b0);
          chk("stall_rvalid", n ? m1_rvalid : m0_rvalid, 1'b1);
          post();
        end
      end
      if (n) m1_rready = 1'b1; else m0_rready = 1'b1;
      @(negedge clk);
      chk("rready", rready, 1'b1);
      if (exp_r.size() == 0) chk("r_queue_empty", 32'd0, 32'd1);
      else begin
        er = exp_r.pop_front();
        chk("rvalid", er.who ? m1_rvalid : m0_rvalid, 1'b1);
        chk("rdata", er.who ? m1_rdata : m0_rdata, er.dat);
        chk("rlast", er.who ? m1_rlast : m0_rlast, er.last);
        chk("other_rvalid", er.who ? m0_rvalid : m1_rvalid, 1'b0);
      end
      post();
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    chk("err", err, exp_err);
  endtask

  initial begin
    rst = 1'b1;
    m0_arvalid = 0; m0_araddr = 0; m0_arlen = 0; m0_arsize = 0; m0_rready = 1;
    m1_arvalid = 0; m1_araddr = 0; m1_arlen = 0; m1_arsize = 0; m1_rready = 1;
    arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
    exp_err = 1'b0;
    post();
    post();
    @(negedge clk);
    chk("rst_arvalid", arvalid, 1'b0);
    chk("rst_rready", rready, 1'b0);
    chk("rst_araddr", araddr, 32'd0);
    chk("rst_arid", arid, ID0);
    chk("rst_err", err, 1'b0);
    chk("rst_rvalid", {m1_rvalid, m0_rvalid, m1_rlast, m0_rlast}, 4'b0000);
    chk("rst_arready", {m1_arready, m0_arready}, 2'b00);
    post();
    rst = 1'b0;

    // m0 only, 8 beats, arready two cycles after arvalid rises
    request(0, 32'h1FC0_0000, 8'd7);
    do_burst(0, 2, 2'b00, 0, -1, -1, 0, -1);

    // contention from reset: m0, then m1 the cycle after rlast, then m0 again
    do_reset();
    request(0, 32'h0000_1000, 8'd1);
    request(1, 32'h0000_2000, 8'd2);
    do_burst(0, 0, 2'b00, 0, -1, -1, 0, -1);
    do_burst(1, 1, 2'b00, 0, -1, -1, 0, -1);
    request(0, 32'h0000_3000, 8'd0);
    request(1, 32'h0000_4000, 8'd0);
    do_burst(0, 0, 2'b00, 0, -1, -1, 0, -1);
    do_burst(1, 0, 2'b00, 0, -1, -1, 0, -1);

    // SLVERR on a single beat is forwarded; err stays sticky through a clean burst
    request(1, 32'h0000_5000, 8'd0);
    do_burst(1, 0, 2'b10, 0, -1, -1, 0, -1);
    request(0, 32'h0000_6000, 8'd3);
    do_burst(0, 1, 2'b00, 0, -1, -1, 0, -1);

    // wrong rid
    do_reset();
    request(0, 32'h0000_7000, 8'd1);
    do_burst(0, 0, 2'b00, 1, -1, -1, 0, -1);

    // early rlast on beat 2 of 4, then FSM must sit idle
    do_reset();
    request(0, 32'h0000_8000, 8'd3);
    do_burst(0, 0, 2'b00, 0, 1, -1, 0, -1);
    idle_check();

    // requester back-pressure for 5 cycles mid-burst
    do_reset();
    request(1, 32'h0000_9000, 8'd7);
    do_burst(1, 1, 2'b00, 0, -1, 3, 5, -1);

    // reset after 3 of 8 beats, then a fresh m1 burst
    request(0, 32'h0000_A000, 8'd7);
    do_burst(0, 0, 2'b00, 0, -1, -1, 0, 3);
    request(1, 32'h0000_B000, 8'd3);
    do_burst(1, 2, 2'b00, 0, -1, -1, 0, -1);
    idle_check();

    chk("ar_queue_drained", exp_ar.size(), 32'd0);
    chk("r_queue_drained", exp_r.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
